// File: rtl/weight_pingpong_buffer.sv
// Purpose: two-bank weight tile buffer between the kernel loader and the systolic array; applies rhs zero-point.
// Latency: a beat is stored at the next edge; the first streamed row appears one cycle after the accepted start pulse.
// Backpressure: buf_ready drops while the write bank is full (late beats are dropped and flagged); the array start is gated by tile_avail.
module weight_pingpong_buffer #(
    parameter int DATA_WIDTH = 8,
    parameter int SIZE       = 16,
    parameter int REG_WIDTH  = 32,
    parameter int OUT_WIDTH  = DATA_WIDTH + 1
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 init_cfg,
    input  logic [REG_WIDTH-1:0]                 rhs_zp,
    input  logic [REG_WIDTH-1:0]                 tile_rows,
    input  logic                                 store_weight_req,
    input  logic [SIZE-1:0][DATA_WIDTH-1:0]      weight_in,
    input  logic                                 weight_sending_done,
    output logic                                 buf_ready,
    input  logic                                 arr_load_start,
    output logic                                 tile_avail,
    output logic                                 arr_row_valid,
    output logic [$clog2(SIZE)-1:0]              arr_row_idx,
    output logic [SIZE-1:0][OUT_WIDTH-1:0]       arr_row_data,
    output logic                                 arr_load_done,
    output logic                                 overflow_err,
    output logic                                 underrun_err
);

    localparam int IW = $clog2(SIZE);
    // Row counters need one extra bit so that a full tile count (SIZE) fits.
    localparam int CW = IW + 1;

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_STREAM = 1'b1;

    // Tile storage: one packed row per entry, two banks.
    logic [SIZE-1:0][DATA_WIDTH-1:0] mem [2][SIZE];

    logic [1:0]            bank_full;
    logic                  wr_ptr;
    logic                  rd_ptr;
    logic [CW-1:0]         wr_row;
    logic [CW-1:0]         rows_cnt [2];
    logic [OUT_WIDTH-1:0]  zp;
    logic [CW-1:0]         cfg_rows;
    logic [0:0]            state;

    logic                  beat_ok;
    logic [CW-1:0]         rows_written;
    logic                  tile_close;
    logic                  start_ok;
    logic                  last_row;
    logic [IW-1:0]         next_idx;
    logic                  row_live;
    logic [SIZE-1:0][OUT_WIDTH-1:0] adj_row;
    logic [CW-1:0]         tile_rows_eff;
    logic [1:0]            full_set;
    logic [1:0]            full_clr;

    // Zero-point bits above the adjusted width never reach the arithmetic.
    logic unused_zp_hi;
    assign unused_zp_hi = ^rhs_zp[REG_WIDTH-1:OUT_WIDTH];

    // Write side may only fill a bank the array is not holding.
    assign buf_ready  = ~bank_full[wr_ptr];
    assign tile_avail = bank_full[rd_ptr] && (state == ST_IDLE);

    assign beat_ok      = store_weight_req && buf_ready;
    assign rows_written = wr_row + {{(CW-1){1'b0}}, beat_ok};
    // A same-cycle beat counts toward the rows closed by an end-of-tile pulse.
    assign tile_close   = (beat_ok && (wr_row == cfg_rows - CW'(1)))
                        || (weight_sending_done && (rows_written != '0));

    assign start_ok = (state == ST_IDLE) && arr_load_start && tile_avail;
    assign last_row = (state == ST_STREAM) && (arr_row_idx == IW'(SIZE - 1));

    // Out-of-range row counts fall back to a full tile.
    assign tile_rows_eff = ((tile_rows == '0) || (tile_rows > REG_WIDTH'(SIZE)))
                         ? CW'(SIZE) : tile_rows[CW-1:0];

    // Close and free always target different banks, so both can land on one edge.
    assign full_set = tile_close ? (2'b01 << wr_ptr) : 2'b00;
    assign full_clr = last_row   ? (2'b01 << rd_ptr) : 2'b00;

    // Build the next row to present: zero-point adjusted, or zeros past the tile's valid rows.
    always_comb begin
        next_idx = start_ok ? '0 : (arr_row_idx + IW'(1));
        row_live = ({1'b0, next_idx} < rows_cnt[rd_ptr]);
        adj_row  = '0;
        for (int e = 0; e < SIZE; e++) begin
            if (row_live) begin
                adj_row[e] = OUT_WIDTH'($signed(mem[rd_ptr][next_idx][e])) - zp;
            end
        end
    end

    // Configuration registers, reloaded on init_cfg.
    always_ff @(posedge clk) begin
        if (rst) begin
            zp       <= '0;
            cfg_rows <= CW'(SIZE);
        end else if (init_cfg) begin
            zp       <= rhs_zp[OUT_WIDTH-1:0];
            cfg_rows <= tile_rows_eff;
        end
    end

    // Write pointer, row counter and per-bank row counts.
    always_ff @(posedge clk) begin
        if (rst || init_cfg) begin
            wr_ptr      <= 1'b0;
            wr_row      <= '0;
            rows_cnt[0] <= '0;
            rows_cnt[1] <= '0;
        end else if (tile_close) begin
            rows_cnt[wr_ptr] <= rows_written;
            wr_ptr           <= ~wr_ptr;
            wr_row           <= '0;
        end else if (beat_ok) begin
            wr_row <= wr_row + CW'(1);
        end
    end

    // Row storage; contents need no reset since rows_cnt masks stale rows.
    always_ff @(posedge clk) begin
        if (beat_ok && !rst && !init_cfg) begin
            mem[wr_ptr][wr_row[IW-1:0]] <= weight_in;
        end
    end

    // Bank ownership flags: set by the loader's close, cleared by the array's last row.
    always_ff @(posedge clk) begin
        if (rst || init_cfg) begin
            bank_full <= 2'b00;
        end else begin
            bank_full <= (bank_full | full_set) & ~full_clr;
        end
    end

    // Read FSM with registered row outputs; always emits SIZE rows per tile.
    always_ff @(posedge clk) begin
        if (rst || init_cfg) begin
            state         <= ST_IDLE;
            rd_ptr        <= 1'b0;
            arr_row_valid <= 1'b0;
            arr_row_idx   <= '0;
            arr_row_data  <= '0;
            arr_load_done <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start_ok) begin
                        state         <= ST_STREAM;
                        arr_row_valid <= 1'b1;
                        arr_row_idx   <= next_idx;
                        arr_row_data  <= adj_row;
                        arr_load_done <= (next_idx == IW'(SIZE - 1));
                    end
                end
                ST_STREAM: begin
                    if (last_row) begin
                        state         <= ST_IDLE;
                        rd_ptr        <= ~rd_ptr;
                        arr_row_valid <= 1'b0;
                        arr_row_idx   <= '0;
                        arr_row_data  <= '0;
                        arr_load_done <= 1'b0;
                    end else begin
                        arr_row_idx   <= next_idx;
                        arr_row_data  <= adj_row;
                        arr_load_done <= (next_idx == IW'(SIZE - 1));
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Sticky protocol error flags.
    always_ff @(posedge clk) begin
        if (rst || init_cfg) begin
            overflow_err <= 1'b0;
            underrun_err <= 1'b0;
        end else begin
            if (store_weight_req && !buf_ready) begin
                overflow_err <= 1'b1;
            end
            if ((state == ST_IDLE) && arr_load_start && !tile_avail) begin
                underrun_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_weight_pingpong_buffer.sv
// Purpose: directed self-checking bench for weight_pingpong_buffer.
// Latency: inputs driven 1ns after the rising edge, outputs sampled at that same point.
// Backpressure: loader waits on buf_ready, array start waits on tile_avail, all waits bounded.
module tb_weight_pingpong_buffer;

    localparam int DATA_WIDTH = 8;
    localparam int SIZE       = 16;
    localparam int REG_WIDTH  = 32;
    localparam int OUT_WIDTH  = DATA_WIDTH + 1;
    localparam int IW         = $clog2(SIZE);

    logic                             clk = 1'b0;
    logic                             rst;
    logic                             init_cfg;
    logic [REG_WIDTH-1:0]             rhs_zp;
    logic [REG_WIDTH-1:0]             tile_rows;
    logic                             store_weight_req;
    logic [SIZE-1:0][DATA_WIDTH-1:0]  weight_in;
    logic                             weight_sending_done;
    logic                             buf_ready;
    logic                             arr_load_start;
    logic                             tile_avail;
    logic                             arr_row_valid;
    logic [IW-1:0]                    arr_row_idx;
    logic [SIZE-1:0][OUT_WIDTH-1:0]   arr_row_data;
    logic                             arr_load_done;
    logic                             overflow_err;
    logic                             underrun_err;

    int n_checks = 0;
    int n_err    = 0;
    int exp_val [SIZE];
    int exp_br   = -1;
    int ld_row   = -1;
    int n_coinc  = 0;

    weight_pingpong_buffer #(
        .DATA_WIDTH(DATA_WIDTH), .SIZE(SIZE), .REG_WIDTH(REG_WIDTH), .OUT_WIDTH(OUT_WIDTH)
    ) dut (
        .clk(clk), .rst(rst), .init_cfg(init_cfg), .rhs_zp(rhs_zp), .tile_rows(tile_rows),
        .store_weight_req(store_weight_req), .weight_in(weight_in),
        .weight_sending_done(weight_sending_done), .buf_ready(buf_ready),
        .arr_load_start(arr_load_start), .tile_avail(tile_avail),
        .arr_row_valid(arr_row_valid), .arr_row_idx(arr_row_idx),
        .arr_row_data(arr_row_data), .arr_load_done(arr_load_done),
        .overflow_err(overflow_err), .underrun_err(underrun_err)
    );

    always #5 clk = ~clk;

    // Count edges where a tile closes while the array finishes the other bank.
    always @(negedge clk) begin
        if (store_weight_req && buf_ready && ld_row == SIZE - 1 && arr_load_done) n_coinc++;
    end

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [SIZE*DATA_WIDTH-1:0] wrow(input int v);
        logic [SIZE*DATA_WIDTH-1:0] r;
        for (int e = 0; e < SIZE; e++) r[e*DATA_WIDTH +: DATA_WIDTH] = v[DATA_WIDTH-1:0];
        return r;
    endfunction

    function automatic logic [SIZE*OUT_WIDTH-1:0] make_row(input int v);
        logic [SIZE*OUT_WIDTH-1:0] r;
        for (int e = 0; e < SIZE; e++) r[e*OUT_WIDTH +: OUT_WIDTH] = v[OUT_WIDTH-1:0];
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input int v);
        store_weight_req = 1'b1;
        weight_in = wrow(v);
        tick();
        store_weight_req = 1'b0;
    endtask

    task automatic do_init(input int zp, input int rows);
        init_cfg = 1'b1;
        rhs_zp = zp;
        tile_rows = rows;
        tick();
        init_cfg = 1'b0;
    endtask

    // Pulse start, then check all SIZE rows against exp_val and the cycle after done.
    task automatic run_stream(input string tag);
        arr_load_start = 1'b1;
        tick();
        arr_load_start = 1'b0;
        for (int i = 0; i < SIZE; i++) begin
            check({tag, "_vld"}, arr_row_valid, 1'b1);
            check({tag, "_idx"}, arr_row_idx, i);
            check({tag, "_dat"}, arr_row_data, make_row(exp_val[i]));
            check({tag, "_done"}, arr_load_done, (i == SIZE - 1));
            if (exp_br >= 0) check({tag, "_br"}, buf_ready, exp_br);
            tick();
        end
        check({tag, "_vld_after"}, arr_row_valid, 1'b0);
        check({tag, "_done_after"}, arr_load_done, 1'b0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; init_cfg = 1'b0; rhs_zp = '0; tile_rows = '0;
        store_weight_req = 1'b0; weight_in = '0; weight_sending_done = 1'b0;
        arr_load_start = 1'b0;
        tick(); tick(); tick();
        rst = 1'b0;

        // Reset state.
        check("rst_br", buf_ready, 1'b1);
        check("rst_avail", tile_avail, 1'b0);
        check("rst_vld", arr_row_valid, 1'b0);
        check("rst_idx", arr_row_idx, 0);
        check("rst_dat", arr_row_data, 0);
        check("rst_done", arr_load_done, 1'b0);
        check("rst_ovf", overflow_err, 1'b0);
        check("rst_udr", underrun_err, 1'b0);

        // Full tile, zp=-3: row i streams as i+3.
        do_init(-3, 16);
        for (int i = 0; i < SIZE; i++) begin
            if (i == SIZE - 1) check("t1_avail_pre", tile_avail, 1'b0);
            beat(i);
        end
        check("t1_avail", tile_avail, 1'b1);
        check("t1_br", buf_ready, 1'b1);
        for (int i = 0; i < SIZE; i++) exp_val[i] = i + 3;
        exp_br = 1;
        run_stream("t1");

        // Short tile closes by count: rows 0..4 = 7-2, rest zero.
        do_init(2, 5);
        for (int i = 0; i < 5; i++) begin
            if (i == 4) check("t2_avail_pre", tile_avail, 1'b0);
            beat(7);
        end
        check("t2_avail", tile_avail, 1'b1);
        for (int i = 0; i < SIZE; i++) exp_val[i] = (i < 5) ? 5 : 0;
        exp_br = 1;
        run_stream("t2");

        // End-of-tile pulse: empty pulse ignored, 3 rows of -128 with zp=127 give -255.
        do_init(127, 16);
        weight_sending_done = 1'b1; tick(); weight_sending_done = 1'b0;
        check("t3_empty_done", tile_avail, 1'b0);
        check("t3_empty_br", buf_ready, 1'b1);
        for (int i = 0; i < 3; i++) beat(-128);
        check("t3_avail_pre", tile_avail, 1'b0);
        weight_sending_done = 1'b1; tick(); weight_sending_done = 1'b0;
        check("t3_avail", tile_avail, 1'b1);
        for (int i = 0; i < SIZE; i++) exp_val[i] = (i < 3) ? -255 : 0;
        exp_br = -1;
        run_stream("t3");

        // Both banks full, overflow beat dropped; tile_rows=0 means a full tile.
        do_init(0, 0);
        for (int i = 0; i < 2 * SIZE; i++) begin
            if (i == 2 * SIZE - 1) check("t4_br_pre", buf_ready, 1'b1);
            beat((i < SIZE) ? (i + 20) : (-50 - (i - SIZE)));
        end
        check("t4_br_full", buf_ready, 1'b0);
        check("t4_ovf_pre", overflow_err, 1'b0);
        beat(99);
        check("t4_ovf", overflow_err, 1'b1);
        check("t4_avail", tile_avail, 1'b1);
        for (int i = 0; i < SIZE; i++) exp_val[i] = i + 20;
        exp_br = 0;
        run_stream("t4a");
        check("t4_br_freed", buf_ready, 1'b1);
        check("t4_avail2", tile_avail, 1'b1);
        for (int i = 0; i < SIZE; i++) exp_val[i] = -50 - i;
        exp_br = -1;
        run_stream("t4b");
        check("t4_ovf_sticky", overflow_err, 1'b1);

        // Underrun, then reset during streaming.
        do_init(0, 16);
        check("t5_ovf_clr", overflow_err, 1'b0);
        arr_load_start = 1'b1; tick(); arr_load_start = 1'b0;
        check("t5_udr", underrun_err, 1'b1);
        check("t5_udr_vld", arr_row_valid, 1'b0);
        tick();
        check("t5_udr_vld2", arr_row_valid, 1'b0);
        for (int i = 0; i < SIZE; i++) beat(i);
        arr_load_start = 1'b1; tick(); arr_load_start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            check("t5_idx", arr_row_idx, i);
            check("t5_done", arr_load_done, 1'b0);
            if (i < 7) tick();
        end
        check("t5_vld_row7", arr_row_valid, 1'b1);
        rst = 1'b1; tick(); rst = 1'b0;
        check("t5_rst_vld", arr_row_valid, 1'b0);
        check("t5_rst_done", arr_load_done, 1'b0);
        check("t5_rst_idx", arr_row_idx, 0);
        check("t5_rst_dat", arr_row_data, 0);
        check("t5_rst_br", buf_ready, 1'b1);
        check("t5_rst_avail", tile_avail, 1'b0);
        check("t5_rst_udr", underrun_err, 1'b0);

        // Continuous traffic, four tiles; tile_rows=40 clamps to a full tile, zp=1.
        do_init(1, 40);
        fork
            begin
                for (int t = 0; t < 4; t++) begin
                    store_weight_req = 1'b0;
                    tick();
                    for (int i = 0; i < SIZE; i++) begin
                        int w;
                        w = 0;
                        store_weight_req = 1'b0;
                        ld_row = -1;
                        while (!buf_ready && w < 200) begin
                            tick();
                            w++;
                        end
                        if (w >= 200) check("t6_ld_timeout", 1'b0, 1'b1);
                        store_weight_req = 1'b1;
                        weight_in = wrow(t * SIZE + i - 30);
                        ld_row = i;
                        tick();
                    end
                    store_weight_req = 1'b0;
                    ld_row = -1;
                end
            end
            begin
                for (int t = 0; t < 4; t++) begin
                    int w;
                    w = 0;
                    while (!tile_avail && w < 200) begin
                        tick();
                        w++;
                    end
                    if (w >= 200) begin
                        check("t6_avail_timeout", 1'b0, 1'b1);
                        break;
                    end
                    for (int i = 0; i < SIZE; i++) exp_val[i] = t * SIZE + i - 31;
                    exp_br = -1;
                    run_stream("t6");
                end
            end
        join
        check("t6_coincide", (n_coinc > 0), 1'b1);
        check("t6_ovf", overflow_err, 1'b0);
        check("t6_udr", underrun_err, 1'b0);
        check("t6_avail_end", tile_avail, 1'b0);
        check("t6_br_end", buf_ready, 1'b1);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/weight_pingpong_buffer.md
Name: weight_pingpong_buffer

Overview:
- Sits directly downstream of the kernel loader and upstream of the systolic array's weight registers.
- Captures row-wise weight beats (store_weight_req / weight_in) into one of two tile banks and applies the rhs zero-point.
- Streams a complete SIZE-row tile into the array on request.
- The ping-pong scheme lets the loader fetch tile t+1 while the array consumes tile t.

Parameters:
- DATA_WIDTH, 8, raw weight element width (signed).
- SIZE, 16, array dimension; rows per bank and elements per row.
- REG_WIDTH, 32, config register width.
- OUT_WIDTH, DATA_WIDTH+1, zero-point-adjusted element width (signed).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- init_cfg  in  1  latches config; flushes both banks
- rhs_zp  in  REG_WIDTH  signed weight zero-point, sampled on init_cfg
- tile_rows  in  REG_WIDTH  valid rows per tile (k), sampled on init_cfg
- store_weight_req  in  1  weight row beat valid
- weight_in  in  SIZE x DATA_WIDTH  signed row data
- weight_sending_done  in  1  loader's end-of-tile pulse
- buf_ready  out  1  write bank free; loader may send
- arr_load_start  in  1  array request for the next tile (pulse)
- tile_avail  out  1  read bank holds a closed tile
- arr_row_valid  out  1  arr_row_data valid this cycle
- arr_row_idx  out  $clog2(SIZE)  row index being streamed
- arr_row_data  out  SIZE x OUT_WIDTH  signed adjusted row
- arr_load_done  out  1  pulse on the last streamed row
- overflow_err  out  1  sticky: beat arrived while buf_ready=0
- underrun_err  out  1  sticky: arr_load_start with no tile available

Behaviour:
- Reset (rst=1 at a clock edge), all registered outputs are 0:
  - bank_full[1:0]=0, wr_ptr=rd_ptr=0, wr_row=0, rows_cnt[b]=0.
  - zp=0, cfg_rows=SIZE, read FSM in IDLE.
  - buf_ready=1 (combinational ~bank_full[wr_ptr]); tile_avail=0.
- Reset mid-stream aborts streaming with no arr_load_done.
- init_cfg has the same clearing effect as reset, except it latches zp=rhs_zp and cfg_rows=tile_rows.
  - tile_rows=0 or >SIZE is treated as SIZE.
  - init_cfg has priority over every same-cycle event.
- Write side:
  - A beat with buf_ready=1 writes weight_in to bank[wr_ptr] row wr_row; wr_row increments.
  - The tile closes when the beat writes row cfg_rows-1, or when weight_sending_done=1 with wr_row>0 (including a beat in the same cycle, which is written first).
  - On close, at the next edge: bank_full[wr_ptr]=1, rows_cnt[wr_ptr]=rows written, wr_ptr toggles, wr_row=0.
  - weight_sending_done with no rows written and no beat is ignored.
  - A beat with buf_ready=0 is dropped and sets overflow_err.
- Read FSM states:
  - IDLE: if arr_load_start and tile_avail, go to STREAM, r=0. If arr_load_start and !tile_avail, set underrun_err and stay. arr_load_start while in STREAM is ignored.
  - STREAM: registered outputs; the first row appears on the cycle after the start pulse.
    - Each cycle: arr_row_valid=1, arr_row_idx=r, arr_row_data = row r of bank[rd_ptr] adjusted.
    - r increments every cycle; exactly SIZE rows are always emitted.
    - Rows r >= rows_cnt[rd_ptr] output all zeros (not -zp).
    - On r=SIZE-1: arr_load_done=1 in the same cycle. At the following edge bank_full[rd_ptr]=0, rd_ptr toggles, return to IDLE.
  - A new start accepted in the cycle after done yields back-to-back tiles with a one-cycle gap.
- tile_avail = bank_full[rd_ptr] && FSM==IDLE.
- Arithmetic per element: sign-extend w to OUT_WIDTH, subtract the low OUT_WIDTH bits of zp, keep the low OUT_WIDTH bits.
  - Correct for zp in [-128,127] (result range [-255,255]).
  - Other zp values are outside the contract; the result wraps.
- Simultaneous tile close on the write side and bank free on the read side: both updates apply in the same edge.
- buf_ready reflects the free at the next cycle.

Test Plan:
- Reset then init_cfg with zp=-3, rows=16; send 16 beats with row i = all i; arr_load_start -> tile_avail=1 after the 16th beat. Rows 0..15 stream on consecutive cycles with data i+3; arr_load_done on row 15; buf_ready=1 throughout.
- rows=5, zp=2: 5 beats of 7 -> tile closes automatically. Stream gives rows 0..4 = 5, rows 5..15 = 0.
- rows=16: 3 beats of -128 then weight_sending_done; zp=127 -> rows 0..2 = -255, rest 0. Also: a done pulse with no beats -> no tile (tile_avail stays 0).
- Fill both banks (32 beats) -> buf_ready=0. A 33rd beat is dropped and overflow_err=1. Start a stream; in the cycle after arr_load_done buf_ready=1 and bank contents are intact.
- arr_load_start with no tile -> underrun_err=1, no arr_row_valid. Assert rst mid-stream at row 7 -> all outputs 0 next cycle, no done pulse, buf_ready=1.
- Continuous loader traffic with a start issued each cycle after done -> four tiles stream in order with no data mixing between banks. Close and free land on the same edge at least once.
